// File: rtl/gol_pkg.sv
// gol_pkg: shared state encoding, default grid sizes and rule masks
// for the Game of Life engine, plus a row popcount helper.
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    SWAP
  } state_t;

  localparam int DEF_WIDTH = 50;
  localparam int DEF_HEIGHT = 40;
  localparam logic [8:0] DEF_BIRTH = 9'b000001000;
  localparam logic [8:0] DEF_SURVIVE = 9'b000001100;

  // Widest row the popcount helper accepts.
  localparam int POP_MAX_W = 256;

  function automatic int unsigned popcount(
    input logic [POP_MAX_W-1:0] v
  );
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      c += 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/gol_row_update.sv
// gol_row_update: combinational next-state of one row from the rows
// above/current/below. Ports: above, cur, below in; next_row out.
module gol_row_update
  import gol_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter bit WRAP = 1'b0,
  parameter logic [8:0] BIRTH_MASK = DEF_BIRTH,
  parameter logic [8:0] SURVIVE_MASK = DEF_SURVIVE
) (
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] below,
  output logic [WIDTH-1:0] next_row
);

  // Rows padded with column -1 at bit 0 and column WIDTH at the MSB,
  // so cell x sees its 3-wide window at ext[x+2:x].
  logic [WIDTH+1:0] a_ext;
  logic [WIDTH+1:0] c_ext;
  logic [WIDTH+1:0] b_ext;

  assign a_ext = {WRAP ? above[0] : 1'b0, above,
                  WRAP ? above[WIDTH-1] : 1'b0};
  assign c_ext = {WRAP ? cur[0] : 1'b0, cur,
                  WRAP ? cur[WIDTH-1] : 1'b0};
  assign b_ext = {WRAP ? below[0] : 1'b0, below,
                  WRAP ? below[WIDTH-1] : 1'b0};

  for (genvar x = 0; x < WIDTH; x++) begin : g_cell
    logic [3:0] sum9;
    logic [3:0] n;
    // Full 3x3 window minus the centre gives the neighbour count.
    assign sum9 = 4'(a_ext[x]) + 4'(a_ext[x+1]) + 4'(a_ext[x+2])
                + 4'(c_ext[x]) + 4'(c_ext[x+1]) + 4'(c_ext[x+2])
                + 4'(b_ext[x]) + 4'(b_ext[x+1]) + 4'(b_ext[x+2]);
    assign n = sum9 - 4'(cur[x]);
    assign next_row[x] = cur[x] ? SURVIVE_MASK[n] : BIRTH_MASK[n];
  end

endmodule

// File: rtl/gol_grid_engine.sv
// gol_grid_engine: double-buffered, row-per-cycle Game of Life engine.
// Ports: Clk/Reset, step/run/speed control, seed write, rd_row/rd_data
// display read, busy/gen_done/gen_count/population/overrun status.
module gol_grid_engine
  import gol_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int WRAP = 0,
  parameter logic [8:0] BIRTH_MASK = DEF_BIRTH,
  parameter logic [8:0] SURVIVE_MASK = DEF_SURVIVE,
  parameter int CLK_HZ = 50000000,
  parameter int SEED_ROW = 5,
  parameter int SEED_COL = 10,
  localparam int RW = $clog2(HEIGHT),
  localparam int PW = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             step,
  input  logic             run,
  input  logic [3:0]       speed,
  input  logic             seed_we,
  input  logic [RW-1:0]    seed_row,
  input  logic [WIDTH-1:0] seed_data,
  input  logic [RW-1:0]    rd_row,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             gen_done,
  output logic [31:0]      gen_count,
  output logic [PW-1:0]    population,
  output logic             overrun
);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] bank [2][HEIGHT];
  logic             front;
  logic [RW-1:0]    r;
  logic [PW-1:0]    acc;
  logic [31:0]      per_cnt;
  logic [31:0]      period;
  logic             tick;
  logic             start;
  logic             seed_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] above;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] below;
  logic [WIDTH-1:0] next_row;
  logic [PW-1:0]    row_pop;

  function automatic logic [WIDTH-1:0] seed_pat(input int y);
    logic [WIDTH-1:0] v;
    v = {{(WIDTH-1){1'b0}}, 1'b1} << SEED_COL;
    if (y == SEED_ROW) v = '1;
    return v;
  endfunction

  assign period = 32'(CLK_HZ) >> speed;
  assign tick = run && ((per_cnt + 32'd1) >= period);

  assign busy = (state != IDLE);
  assign gen_done = (state == SWAP);

  // A seed write in the same cycle swallows the start request.
  assign start = (step | tick) & ~seed_we;
  assign seed_ok = (32'(seed_row) < HEIGHT);
  assign rd_ok = (32'(rd_row) < HEIGHT);

  always_comb begin
    above = '0;
    below = '0;
    cur = bank[front][r];
    if (r != '0) above = bank[front][r - RW'(1)];
    else if (WRAP != 0) above = bank[front][HEIGHT-1];
    if (r != RW'(HEIGHT-1)) below = bank[front][r + RW'(1)];
    else if (WRAP != 0) below = bank[front][0];
  end

  gol_row_update #(
    .WIDTH(WIDTH),
    .WRAP(WRAP != 0),
    .BIRTH_MASK(BIRTH_MASK),
    .SURVIVE_MASK(SURVIVE_MASK)
  ) u_row (
    .above(above),
    .cur(cur),
    .below(below),
    .next_row(next_row)
  );

  assign row_pop = PW'(popcount(POP_MAX_W'(next_row)));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && !seed_we) state_nxt = COMPUTE;
      COMPUTE: if (r == RW'(HEIGHT-1)) state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset || !run || tick) per_cnt <= '0;
    else per_cnt <= per_cnt + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int y = 0; y < HEIGHT; y++) begin
        bank[0][y] <= seed_pat(y);
        bank[1][y] <= seed_pat(y);
      end
      front <= 1'b0;
      r <= '0;
      acc <= '0;
      rd_data <= '0;
      gen_count <= '0;
      population <= '0;
      overrun <= 1'b0;
    end else begin
      // The swap cycle still reads the old front; front flips after.
      rd_data <= rd_ok ? bank[front][rd_row] : '0;
      if (tick && busy) overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          r <= '0;
          acc <= '0;
          if (seed_we && seed_ok) bank[front][seed_row] <= seed_data;
        end
        COMPUTE: begin
          bank[~front][r] <= next_row;
          acc <= acc + row_pop;
          r <= r + RW'(1);
        end
        SWAP: begin
          front <= ~front;
          gen_count <= gen_count + 32'd1;
          population <= acc;
        end
        default: r <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_grid_engine.sv
// tb_gol_grid_engine: scenario tasks with a row scoreboard queue and a
// small reference Life model, over four engine configurations.
module tb_gol_grid_engine;

  typedef logic [7:0] grid_t [8];

  localparam logic [8:0] B3 = 9'b000001000;
  localparam logic [8:0] S23 = 9'b000001100;
  localparam logic [8:0] B36 = 9'b001001000;

  logic clk;
  logic rst;
  logic step;
  logic run;
  logic [3:0] speed;
  logic seed_we;
  logic [2:0] seed_row;
  logic [7:0] seed_data;
  logic [2:0] rd_row;
  logic [5:0] rd_row_big;

  logic [49:0] rd_big;
  logic busy_big, done_big, ovr_big;
  logic [31:0] gc_big;
  logic [10:0] pop_big;

  logic [7:0] rd_dut, rd_tor, rd_b36;
  logic busy_dut, busy_tor, busy_b36;
  logic done_dut, done_tor, done_b36;
  logic ovr_dut, ovr_tor, ovr_b36;
  logic [31:0] gc_dut, gc_tor, gc_b36;
  logic [6:0] pop_dut, pop_tor, pop_b36;

  int n_tests;
  int n_fail;
  logic [7:0] exp_q[$];
  logic [49:0] big_q[$];

  gol_grid_engine u_big (
    .Clk(clk), .Reset(rst), .step(1'b0), .run(1'b0),
    .speed(4'd0), .seed_we(1'b0), .seed_row(6'd0),
    .seed_data(50'd0), .rd_row(rd_row_big), .rd_data(rd_big),
    .busy(busy_big), .gen_done(done_big), .gen_count(gc_big),
    .population(pop_big), .overrun(ovr_big)
  );

  gol_grid_engine #(
    .WIDTH(8), .HEIGHT(8), .WRAP(0), .CLK_HZ(64), .SEED_COL(6)
  ) u_dut (
    .Clk(clk), .Reset(rst), .step(step), .run(run),
    .speed(speed), .seed_we(seed_we), .seed_row(seed_row),
    .seed_data(seed_data), .rd_row(rd_row), .rd_data(rd_dut),
    .busy(busy_dut), .gen_done(done_dut), .gen_count(gc_dut),
    .population(pop_dut), .overrun(ovr_dut)
  );

  gol_grid_engine #(
    .WIDTH(8), .HEIGHT(8), .WRAP(1), .CLK_HZ(64), .SEED_COL(6)
  ) u_tor (
    .Clk(clk), .Reset(rst), .step(step), .run(run),
    .speed(speed), .seed_we(seed_we), .seed_row(seed_row),
    .seed_data(seed_data), .rd_row(rd_row), .rd_data(rd_tor),
    .busy(busy_tor), .gen_done(done_tor), .gen_count(gc_tor),
    .population(pop_tor), .overrun(ovr_tor)
  );

  gol_grid_engine #(
    .WIDTH(8), .HEIGHT(8), .WRAP(0), .BIRTH_MASK(B36),
    .CLK_HZ(64), .SEED_COL(6)
  ) u_b36 (
    .Clk(clk), .Reset(rst), .step(step), .run(run),
    .speed(speed), .seed_we(seed_we), .seed_row(seed_row),
    .seed_data(seed_data), .rd_row(rd_row), .rd_data(rd_b36),
    .busy(busy_b36), .gen_done(done_b36), .gen_count(gc_b36),
    .population(pop_b36), .overrun(ovr_b36)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic grid_t life(input grid_t g, input bit wrap,
                                 input logic [8:0] b,
                                 input logic [8:0] s);
    grid_t o;
    o = g;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int yy;
            int xx;
            yy = y + dy;
            xx = x + dx;
            if (wrap) begin
              yy = (yy + 8) % 8;
              xx = (xx + 8) % 8;
            end
            if (!(dx == 0 && dy == 0) && yy >= 0 && yy < 8 &&
                xx >= 0 && xx < 8)
              n += int'(g[yy][xx]);
          end
        end
        o[y][x] = g[y][x] ? s[n] : b[n];
      end
    end
    return o;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic seed_grid(input grid_t g);
    for (int y = 0; y < 8; y++) begin
      seed_we = 1'b1;
      seed_row = 3'(y);
      seed_data = g[y];
      cyc();
    end
    seed_we = 1'b0;
  endtask

  task automatic do_step(output int lat);
    step = 1'b1;
    cyc();
    step = 1'b0;
    lat = 1;
    while (done_dut !== 1'b1 && lat < 40) begin
      cyc();
      lat++;
    end
    cyc();
  endtask

  task automatic read_grid(output grid_t gd, output grid_t gt,
                           output grid_t gb);
    for (int y = 0; y < 8; y++) begin
      rd_row = 3'(y);
      cyc();
      gd[y] = rd_dut;
      gt[y] = rd_tor;
      gb[y] = rd_b36;
    end
  endtask

  task automatic test_reset();
    logic [49:0] e;
    do_reset();
    n_tests++;
    if (rd_dut !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %h want 00", rd_dut);
    end
    n_tests++;
    if ({busy_big, done_big, ovr_big, busy_dut, done_dut, ovr_dut,
         busy_tor, done_tor, ovr_tor, busy_b36, done_b36, ovr_b36}
        !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0", {busy_big, done_big,
               ovr_big, busy_dut, done_dut, ovr_dut});
    end
    n_tests++;
    if ({gc_big, gc_dut, gc_tor, gc_b36} !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_gen_count: got %0d/%0d want 0",
               gc_big, gc_dut);
    end
    n_tests++;
    if ({pop_big, pop_dut, pop_tor, pop_b36} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_population: got %0d/%0d want 0",
               pop_big, pop_dut);
    end
    for (int y = 0; y < 40; y++) begin
      e = (y == 5) ? {50{1'b1}} : (50'd1 << 10);
      big_q.push_back(e);
    end
    for (int y = 0; y < 40; y++) begin
      rd_row_big = 6'(y);
      cyc();
      e = big_q.pop_front();
      n_tests++;
      if (rd_big !== e) begin
        n_fail++;
        $display("FAIL reset_row%0d: got %h want %h", y, rd_big, e);
      end
    end
  endtask

  task automatic test_blinker();
    grid_t g0, gd, gt, gb;
    int lat;
    logic [7:0] e;
    do_reset();
    g0 = '{default: 8'h00};
    g0[3] = 8'b0001_1100;
    seed_grid(g0);
    do_step(lat);
    n_tests++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL blink_latency: got %0d want 9", lat);
    end
    n_tests++;
    if (gc_dut !== 32'd1 || pop_dut !== 7'd3 || busy_dut !== 1'b0) begin
      n_fail++;
      $display("FAIL blink_status: got gc=%0d pop=%0d busy=%b want 1 3 0",
               gc_dut, pop_dut, busy_dut);
    end
    for (int y = 0; y < 8; y++)
      exp_q.push_back((y >= 2 && y <= 4) ? 8'h08 : 8'h00);
    read_grid(gd, gt, gb);
    for (int y = 0; y < 8; y++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (gd[y] !== e) begin
        n_fail++;
        $display("FAIL blink1_row%0d: got %h want %h", y, gd[y], e);
      end
    end
    do_step(lat);
    for (int y = 0; y < 8; y++) exp_q.push_back(g0[y]);
    read_grid(gd, gt, gb);
    for (int y = 0; y < 8; y++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (gd[y] !== e) begin
        n_fail++;
        $display("FAIL blink2_row%0d: got %h want %h", y, gd[y], e);
      end
    end
    n_tests++;
    if (gc_dut !== 32'd2) begin
      n_fail++;
      $display("FAIL blink_gen_count: got %0d want 2", gc_dut);
    end
  endtask

  task automatic test_glider();
    grid_t g0, gm, gd, gt, gb;
    int lat;
    logic [7:0] e;
    do_reset();
    g0 = '{default: 8'h00};
    g0[5] = 8'h40;
    g0[6] = 8'h80;
    g0[7] = 8'hE0;
    seed_grid(g0);
    gm = g0;
    for (int i = 0; i < 32; i++) begin
      do_step(lat);
      gm = life(gm, 1'b1, B3, S23);
      n_tests++;
      if (pop_tor !== 7'd5) begin
        n_fail++;
        $display("FAIL glider_pop_gen%0d: got %0d want 5", i, pop_tor);
      end
      for (int y = 0; y < 8; y++) exp_q.push_back(gm[y]);
      read_grid(gd, gt, gb);
      for (int y = 0; y < 8; y++) begin
        e = exp_q.pop_front();
        n_tests++;
        if (gt[y] !== e) begin
          n_fail++;
          $display("FAIL glider_gen%0d_row%0d: got %h want %h",
                   i, y, gt[y], e);
        end
      end
    end
    for (int y = 0; y < 8; y++) exp_q.push_back(g0[y]);
    for (int y = 0; y < 8; y++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (gt[y] !== e) begin
        n_fail++;
        $display("FAIL glider_return_row%0d: got %h want %h", y, gt[y], e);
      end
    end
    for (int y = 0; y < 8; y++)
      exp_q.push_back((y >= 6) ? 8'hC0 : 8'h00);
    for (int y = 0; y < 8; y++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (gd[y] !== e) begin
        n_fail++;
        $display("FAIL block_row%0d: got %h want %h", y, gd[y], e);
      end
    end
    n_tests++;
    if (pop_dut !== 7'd4 || gc_dut !== 32'd32) begin
      n_fail++;
      $display("FAIL block_status: got pop=%0d gc=%0d want 4 32",
               pop_dut, gc_dut);
    end
  endtask

  task automatic test_run_timing();
    int lat;
    do_reset();
    speed = 4'd2;
    run = 1'b1;
    lat = 0;
    while (done_dut !== 1'b1 && lat < 60) begin
      cyc();
      lat++;
    end
    n_tests++;
    if (lat !== 24) begin
      n_fail++;
      $display("FAIL run_first_done: got %0d want 24", lat);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      lat = 1;
      while (done_dut !== 1'b1 && lat < 60) begin
        cyc();
        lat++;
      end
      n_tests++;
      if (lat !== 16) begin
        n_fail++;
        $display("FAIL run_period%0d: got %0d want 16", i, lat);
      end
    end
    n_tests++;
    if (ovr_dut !== 1'b0) begin
      n_fail++;
      $display("FAIL run_no_overrun: got %b want 0", ovr_dut);
    end
    speed = 4'd4;
    repeat (40) cyc();
    n_tests++;
    if (ovr_dut !== 1'b1) begin
      n_fail++;
      $display("FAIL run_overrun: got %b want 1", ovr_dut);
    end
    run = 1'b0;
    speed = 4'd0;
    repeat (12) cyc();
    do_reset();
    n_tests++;
    if (ovr_dut !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b want 0", ovr_dut);
    end
  endtask

  task automatic test_busy_inputs();
    grid_t g0, gd, gt, gb;
    int k;
    logic [7:0] e;
    do_reset();
    g0 = '{default: 8'h00};
    g0[3] = 8'b0001_1100;
    seed_grid(g0);
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    cyc();
    seed_we = 1'b1;
    seed_row = 3'd3;
    seed_data = 8'hFF;
    step = 1'b1;
    rd_row = 3'd3;
    cyc();
    seed_we = 1'b0;
    step = 1'b0;
    n_tests++;
    if (busy_dut !== 1'b1 || rd_dut !== 8'h1C) begin
      n_fail++;
      $display("FAIL busy_front: got busy=%b row3=%h want 1 1c",
               busy_dut, rd_dut);
    end
    k = 0;
    while (done_dut !== 1'b1 && k < 20) begin
      cyc();
      k++;
    end
    n_tests++;
    if (done_dut !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_done: got %b want 1", done_dut);
    end
    repeat (12) cyc();
    n_tests++;
    if (busy_dut !== 1'b0 || gc_dut !== 32'd1) begin
      n_fail++;
      $display("FAIL busy_ignored_step: got busy=%b gc=%0d want 0 1",
               busy_dut, gc_dut);
    end
    for (int y = 0; y < 8; y++)
      exp_q.push_back((y >= 2 && y <= 4) ? 8'h08 : 8'h00);
    read_grid(gd, gt, gb);
    for (int y = 0; y < 8; y++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (gd[y] !== e) begin
        n_fail++;
        $display("FAIL busy_seed_row%0d: got %h want %h", y, gd[y], e);
      end
    end
    seed_we = 1'b1;
    seed_row = 3'd0;
    seed_data = 8'h81;
    step = 1'b1;
    cyc();
    seed_we = 1'b0;
    step = 1'b0;
    n_tests++;
    if (busy_dut !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_priority_busy: got %b want 0", busy_dut);
    end
    exp_q.push_back(8'h81);
    rd_row = 3'd0;
    cyc();
    e = exp_q.pop_front();
    n_tests++;
    if (rd_dut !== e) begin
      n_fail++;
      $display("FAIL seed_priority_row0: got %h want %h", rd_dut, e);
    end
  endtask

  task automatic test_reset_mid();
    grid_t gd, gt, gb;
    int lat;
    int pulses;
    logic [7:0] e;
    do_reset();
    do_step(lat);
    step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (4) cyc();
    n_tests++;
    if (busy_dut !== 1'b1 || gc_dut !== 32'd1) begin
      n_fail++;
      $display("FAIL mid_pre: got busy=%b gc=%0d want 1 1",
               busy_dut, gc_dut);
    end
    do_reset();
    n_tests++;
    if (busy_dut !== 1'b0 || gc_dut !== 32'd0 || done_dut !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b gc=%0d done=%b want 0 0 0",
               busy_dut, gc_dut, done_dut);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (done_dut === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL mid_no_done: got %0d pulses want 0", pulses);
    end
    for (int y = 0; y < 8; y++)
      exp_q.push_back((y == 5) ? 8'hFF : 8'h40);
    read_grid(gd, gt, gb);
    for (int y = 0; y < 8; y++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (gd[y] !== e) begin
        n_fail++;
        $display("FAIL mid_seed_row%0d: got %h want %h", y, gd[y], e);
      end
    end
  endtask

  task automatic test_rule_masks();
    grid_t g0, m3, m36, gd, gt, gb;
    int lat;
    logic [7:0] e;
    do_reset();
    g0 = '{default: 8'h00};
    g0[2] = 8'b0001_1100;
    g0[4] = 8'b0001_1100;
    seed_grid(g0);
    do_step(lat);
    m3 = life(g0, 1'b0, B3, S23);
    m36 = life(g0, 1'b0, B36, S23);
    for (int y = 0; y < 8; y++) exp_q.push_back(m3[y]);
    for (int y = 0; y < 8; y++) exp_q.push_back(m36[y]);
    read_grid(gd, gt, gb);
    n_tests++;
    if (gb[3][3] !== 1'b1 || gd[3][3] !== 1'b0) begin
      n_fail++;
      $display("FAIL rule_centre: got b36=%b b3=%b want 1 0",
               gb[3][3], gd[3][3]);
    end
    for (int y = 0; y < 8; y++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (gd[y] !== e) begin
        n_fail++;
        $display("FAIL rule_b3_row%0d: got %h want %h", y, gd[y], e);
      end
    end
    for (int y = 0; y < 8; y++) begin
      e = exp_q.pop_front();
      n_tests++;
      if (gb[y] !== e) begin
        n_fail++;
        $display("FAIL rule_b36_row%0d: got %h want %h", y, gb[y], e);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    step = 1'b0;
    run = 1'b0;
    speed = 4'd0;
    seed_we = 1'b0;
    seed_row = 3'd0;
    seed_data = 8'h00;
    rd_row = 3'd0;
    rd_row_big = 6'd0;
    repeat (3) cyc();
    test_reset();
    test_blinker();
    test_glider();
    test_run_timing();
    test_busy_inputs();
    test_reset_mid();
    test_rule_masks();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gol_grid_engine.md
Name: gol_grid_engine

Overview:
- Parametrised Game of Life engine that replaces the per-cell, gated-clock grid with a double-buffered, row-sequential update on a single clock.
- Computes one row per cycle from the front bank into the back bank, then swaps banks at the end of each generation.
- Exposes a registered row-read port for the VGA draw path, a seed write port, a generation counter and a population count.
- Supports dead or toroidal boundaries and programmable birth/survive rules.

Parameters:
- WIDTH, 50, cells per row (>=3).
- HEIGHT, 40, rows (>=3).
- WRAP, 0, boundary mode: 0 = outside cells dead, 1 = toroidal.
- BIRTH_MASK, 9'b000001000, bit n set = dead cell with n live neighbours is born (B3).
- SURVIVE_MASK, 9'b000001100, bit n set = live cell with n neighbours survives (S23).
- CLK_HZ, 50000000, base run period in cycles.
- SEED_ROW, 5, row set live at reset.
- SEED_COL, 10, column set live at reset.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- step  in  1  single-generation request pulse.
- run  in  1  free-run enable.
- speed  in  4  run period = CLK_HZ >> speed cycles.
- seed_we  in  1  seed row write strobe.
- seed_row  in  $clog2(HEIGHT)  seed row address.
- seed_data  in  WIDTH  seed row value; bit x = column x.
- rd_row  in  $clog2(HEIGHT)  display row address.
- rd_data  out  WIDTH  front-bank row, 1-cycle latency.
- busy  out  1  generation in progress.
- gen_done  out  1  one-cycle pulse on bank swap.
- gen_count  out  32  generations completed, wraps at 2^32.
- population  out  $clog2(WIDTH*HEIGHT+1)  live cells in the newest generation.
- overrun  out  1  sticky: a run tick arrived while busy.

Behaviour:
- Reset, synchronous, at any time including mid-generation:
  - state IDLE; both banks loaded with the seed pattern (cell live iff x==SEED_COL or y==SEED_ROW); front=bank0.
  - rd_data=0, busy=0, gen_done=0, gen_count=0, population=0, overrun=0, period counter=0.
- Period counter: counts only while run=1.
  - When it reaches (CLK_HZ>>speed)-1 it emits a tick and returns to 0.
  - run=0 holds the counter at 0.
  - A speed change takes effect on the next compare.
- States: IDLE, COMPUTE, SWAP.
- IDLE:
  - Start condition = step | tick. Start → COMPUTE with r=0 and busy=1 on the next cycle.
  - seed_we writes seed_data into the front bank row seed_row. Addresses >= HEIGHT are ignored.
  - seed_we has priority: if seed_we and a start coincide, the write occurs and the start is discarded.
- COMPUTE, one row per cycle, r = 0..HEIGHT-1:
  - Reads front rows r-1, r, r+1 and writes next-state row r into the back bank.
  - Adds popcount(next row r) to a population accumulator.
  - Neighbour columns x-1/x+1 and rows r-1/r+1 outside range are 0 (WRAP=0) or modulo WIDTH/HEIGHT (WRAP=1).
  - Next state = live ? SURVIVE_MASK[n] : BIRTH_MASK[n], with n = 0..8.
  - After r=HEIGHT-1 → SWAP.
- SWAP, one cycle:
  - Toggle front, gen_count+1, population ← accumulator, gen_done=1 for exactly this cycle.
  - → IDLE with busy=0.
- Latency: a start request produces gen_done HEIGHT+1 cycles later.
- Requests while busy:
  - step ignored.
  - tick dropped and overrun set (cleared only by Reset).
  - seed_we ignored.
- rd_data:
  - Registered read of the front bank.
  - A read issued in the SWAP cycle returns the old front; the next cycle returns the new front.
  - rd_row >= HEIGHT returns 0.
  - The display never observes a partially computed generation.

Decomposition:
- gol_pkg holds:
  - state_t enum (IDLE, COMPUTE, SWAP);
  - default WIDTH/HEIGHT/rule mask constants;
  - a popcount function.
- Sub-module gol_row_update: purely combinational.
  - Inputs: above/cur/below rows (WIDTH each) plus WRAP, BIRTH_MASK and SURVIVE_MASK parameters.
  - Output: next row.
  - Instanced once in gol_grid_engine.

Test Plan:
- Reset check (WIDTH=50, HEIGHT=40):
  - Reset → rd_data for row 5 = all ones.
  - Every other row has only bit 10 set.
  - gen_count=0, busy=0.
- Blinker (WIDTH=8, HEIGHT=8, WRAP=0):
  - Seed row 3 = 8'b00011100, others 0; step.
  - gen_done exactly 9 cycles later.
  - Rows 2..4 = 8'b00001000, population=3, gen_count=1.
  - A second step restores row 3 = 8'b00011100.
- Toroidal glider (WRAP=1, 8x8):
  - Glider seeded at the bottom-right corner; 32 steps.
  - Returns to the identical pattern.
  - Population=5 after every generation.
  - Same test with WRAP=0 does not return; the pattern ends as a 2x2 block, population=4.
- Run timing (CLK_HZ=64, speed=2, HEIGHT=8):
  - run=1 → tick every 16 cycles, gen_done every 16 cycles, overrun=0.
  - speed=4 → period 4 < 9 busy cycles, so overrun=1.
- Busy-time inputs:
  - seed_we and step asserted during COMPUTE are ignored; the front bank is unchanged until SWAP.
  - seed_we coinciding with step in IDLE: write lands, busy stays 0.
- Reset mid-COMPUTE (r=4):
  - Next cycle busy=0, seed pattern restored, gen_count=0, no gen_done pulse.
- Rule masks (B36/S23):
  - Cell with 6 live neighbours is born; same stimulus under B3/S23 stays dead.
